restoring_divider_seq: RTL
==========================

Name: restoring_divider_seq

Overview:
- Parametrised sequential restoring divider: N-bit dividend / N-bit divisor -> N-bit quotient and N-bit remainder.
- Controller and datapath in one block; start/busy/done handshake.
- Adds signed (truncating) mode and divide-by-zero detection.
- Sits as an arithmetic unit behind a simple request/response controller; one division in flight at a time.

Parameters:
WIDTH, 6, operand/quotient/remainder width in bits (>=2)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not to be overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
signed_op  input  1  1 = two's-complement operands, 0 = unsigned; captured with start
dividend  input  WIDTH  captured on accepted start
divisor  input  WIDTH  captured on accepted start
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when results are valid
div_by_zero  output  1  set with done when divisor==0; held until next accepted start
quotient  output  WIDTH  result, held stable until next accepted start
remainder  output  WIDTH  result, held stable until next accepted start

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): state=IDLE; busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, counter=0. rst overrides everything, including mid-division; the in-flight operation is lost and no done is produced.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE: start=1 -> accept.
  - Latch sign flags (sd = signed_op & dividend[MSB], sv = signed_op & divisor[MSB]).
  - Q reg = |dividend|, D reg = |divisor| (magnitudes only in signed mode); A reg (WIDTH+1 bits) = 0; counter=0.
  - If divisor==0: next state DONE, with quotient = all ones, remainder = raw dividend, div_by_zero=1.
  - Otherwise: next state CALC, div_by_zero=0.
- CALC, one iteration per cycle:
  - {A,Q} shifted left 1; trial T = A_shifted - {0,D}.
  - If T[MSB]==1 (negative): A keeps the shifted value (restore), Q[0]=0.
  - Otherwise: A=T, Q[0]=1.
  - counter++; after WIDTH iterations (counter==WIDTH-1 on the last one) -> FIX.
- FIX: quotient = (sd^sv) ? -Q : Q; remainder = sd ? -A[WIDTH-1:0] : A[WIDTH-1:0]; -> DONE.
- DONE: done=1 for exactly this cycle; busy=0; -> IDLE. Results held until the next accepted start.
- busy=1 in CALC and FIX (and DONE-for-div0 is not busy).
- Latency: start sampled at edge k -> done high in the cycle following edge k+WIDTH+1 (WIDTH+2 cycles after start). Divide-by-zero: done in the cycle following edge k.
- start while busy or in DONE: ignored, no queuing.
- start in the same cycle done is high: ignored (DONE is not IDLE); re-issue next cycle.
- Signed semantics:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Invariant: dividend == quotient*divisor + remainder (mod 2^WIDTH).
- Signed overflow (most-negative / -1): quotient wraps to most-negative, remainder=0, no flag.
- Unsigned mode: magnitudes equal raw operands; no negation in FIX.
- Operand inputs may change freely after the accepting edge.

Decomposition:
- Shared package divider_pkg holds:
  - state enum (IDLE, CALC, FIX, DONE);
  - a localparam for the divide-by-zero quotient pattern (all ones).
- One combinational sub-module, div_restore_step: inputs A (WIDTH+1), Q (WIDTH), D (WIDTH); outputs next A and next Q for one shift/trial-subtract/restore iteration. Instantiated once in the CALC path.
- Magnitude and negation logic stays inline.

Test Plan:
- WIDTH=6, unsigned 45/7 -> done 8 cycles after start, quotient=6, remainder=3, div_by_zero=0.
- Unsigned 63/1 -> quotient=63, remainder=0; also 5/9 -> quotient=0, remainder=5.
- Divisor 0, dividend 5 -> done in the next cycle, div_by_zero=1, quotient=63, remainder=5; busy never asserts.
- Signed -27/4 -> quotient=-6 (6'b111010), remainder=-3 (6'b111101); signed -32/-1 -> quotient=6'b100000, remainder=0.
- start pulsed during CALC with new operands -> ignored; original result delivered on schedule, single done pulse.
- rst asserted mid-CALC -> next cycle all outputs 0, state IDLE, no done; a fresh 20/3 afterwards -> quotient=6, remainder=2.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Wide enough for any practical WIDTH; users slice the low bits.
  localparam logic [63:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift {A,Q} left, trial-subtract D, restore on borrow.
module div_restore_step #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] a_shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    a_shifted = {a[WIDTH-1:0], q[WIDTH-1]};
    trial     = a_shifted - {1'b0, d};
    q_next    = {q[WIDTH-2:0], 1'b0};
    a_next    = a_shifted;
    // A stays below D, so a non-negative trial never reaches bit WIDTH.
    if (!trial[WIDTH]) begin
      a_next    = trial;
      q_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/restoring_divider_seq.sv
// Sequential restoring divider with start/busy/done handshake, signed mode and divide-by-zero flag.
module restoring_divider_seq
  import divider_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  // Handshake: a request is taken only when start=1 while in IDLE; done is a
  // single-cycle pulse and the results stay valid until the next accepted start.
  state_t           state;
  logic             sd, sv;
  logic [WIDTH:0]   a_reg;
  logic [WIDTH-1:0] q_reg, d_reg;
  logic [CNT_W-1:0] cnt;

  logic             in_sd, in_sv;
  logic [WIDTH-1:0] mag_dividend, mag_divisor;
  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    in_sd        = signed_op & dividend[WIDTH-1];
    in_sv        = signed_op & divisor[WIDTH-1];
    mag_dividend = in_sd ? -dividend : dividend;
    mag_divisor  = in_sv ? -divisor : divisor;
  end

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .a      (a_reg),
    .q      (q_reg),
    .d      (d_reg),
    .a_next (a_next),
    .q_next (q_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sd          <= 1'b0;
      sv          <= 1'b0;
      a_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sd    <= in_sd;
            sv    <= in_sv;
            q_reg <= mag_dividend;
            d_reg <= mag_divisor;
            a_reg <= '0;
            cnt   <= '0;
            if (divisor == '0) begin
              quotient    <= DIV0_QUOTIENT[WIDTH-1:0];
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              div_by_zero <= 1'b0;
              busy        <= 1'b1;
              state       <= CALC;
            end
          end
        end
        CALC: begin
          a_reg <= a_next;
          q_reg <= q_next;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          quotient  <= (sd ^ sv) ? -q_reg : q_reg;
          remainder <= sd ? -a_reg[WIDTH-1:0] : a_reg[WIDTH-1:0];
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
